// File: rtl/sad_accum.sv
// Sums N per-pixel SADs into a block SAD and tracks the window minimum; result is registered, valid the cycle after the Nth accept.
// Backpressure: a held result blocks input (in_rdy = ~clr & (~out_vld | out_rdy)); a drain and a new completion may share a cycle.
module sad_accum #(
    parameter int W    = 8,
    parameter int N    = 16,
    parameter int M    = 8,
    parameter int ACCW = W + 2 + $clog2(N),
    parameter int IDXW = $clog2(M)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            in_vld,
    output logic            in_rdy,
    input  logic [W+1:0]    in_sad,
    output logic            out_vld,
    input  logic            out_rdy,
    output logic [ACCW-1:0] out_blk_sad,
    output logic [IDXW-1:0] out_blk_idx,
    output logic [ACCW-1:0] out_best_sad,
    output logic [IDXW-1:0] out_best_idx,
    output logic            out_win_done
);

    localparam int CNTW = $clog2(N);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(N - 1);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(M - 1);

    logic [ACCW-1:0] acc;
    logic [CNTW-1:0] cnt;
    logic [IDXW-1:0] bidx;
    logic [ACCW-1:0] best_sad;
    logic [IDXW-1:0] best_idx;

    logic            accept;
    logic            blk_done;
    logic [ACCW-1:0] blk;
    logic            take_best;
    logic [ACCW-1:0] nxt_best_sad;
    logic [IDXW-1:0] nxt_best_idx;

    assign in_rdy   = ~clr & (~out_vld | out_rdy);
    assign accept   = in_vld & in_rdy;
    assign blk_done = accept & (cnt == CNT_LAST);
    assign blk      = acc + ACCW'(in_sad);

    // Strict compare keeps the earlier block on a tie; block 0 always seeds a new window.
    assign take_best    = (bidx == '0) | (blk < best_sad);
    assign nxt_best_sad = take_best ? blk  : best_sad;
    assign nxt_best_idx = take_best ? bidx : best_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= '0;
            cnt          <= '0;
            bidx         <= '0;
            best_sad     <= '0;
            best_idx     <= '0;
            out_vld      <= 1'b0;
            out_blk_sad  <= '0;
            out_blk_idx  <= '0;
            out_best_sad <= '0;
            out_best_idx <= '0;
            out_win_done <= 1'b0;
        end else if (clr) begin
            acc      <= '0;
            cnt      <= '0;
            bidx     <= '0;
            best_sad <= '0;
            best_idx <= '0;
            out_vld  <= 1'b0;
        end else begin
            if (blk_done) begin
                acc          <= '0;
                cnt          <= '0;
                bidx         <= (bidx == IDX_LAST) ? '0 : bidx + IDXW'(1);
                best_sad     <= nxt_best_sad;
                best_idx     <= nxt_best_idx;
                out_vld      <= 1'b1;
                out_blk_sad  <= blk;
                out_blk_idx  <= bidx;
                out_best_sad <= nxt_best_sad;
                out_best_idx <= nxt_best_idx;
                out_win_done <= (bidx == IDX_LAST);
            end else begin
                if (accept) begin
                    acc <= blk;
                    cnt <= cnt + CNTW'(1);
                end
                if (out_rdy) begin
                    out_vld <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sad_accum.sv
// Directed bench for sad_accum with W=8, N=4, M=3; expected values are hand-computed block sums.
module tb_sad_accum;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        in_vld;
    logic        in_rdy;
    logic [9:0]  in_sad;
    logic        out_vld;
    logic        out_rdy;
    logic [11:0] out_blk_sad;
    logic [1:0]  out_blk_idx;
    logic [11:0] out_best_sad;
    logic [1:0]  out_best_idx;
    logic        out_win_done;

    int n_chk  = 0;
    int n_pass = 0;

    sad_accum #(.W(8), .N(4), .M(3), .ACCW(12), .IDXW(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .in_vld       (in_vld),
        .in_rdy       (in_rdy),
        .in_sad       (in_sad),
        .out_vld      (out_vld),
        .out_rdy      (out_rdy),
        .out_blk_sad  (out_blk_sad),
        .out_blk_idx  (out_blk_idx),
        .out_best_sad (out_best_sad),
        .out_best_idx (out_best_idx),
        .out_win_done (out_win_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic chk_res(input string tag, input int blk_sad, input int blk_idx,
                           input int bsad, input int bidx, input int wdone);
        chk({tag, ".vld"},      32'(out_vld),      32'd1);
        chk({tag, ".blk_sad"},  32'(out_blk_sad),  32'(blk_sad));
        chk({tag, ".blk_idx"},  32'(out_blk_idx),  32'(blk_idx));
        chk({tag, ".best_sad"}, 32'(out_best_sad), 32'(bsad));
        chk({tag, ".best_idx"}, 32'(out_best_idx), 32'(bidx));
        chk({tag, ".win_done"}, 32'(out_win_done), 32'(wdone));
    endtask

    // Drives one beat for one edge; ready must already be high, so every call also checks for bubbles.
    task automatic send(input string tag, input logic [9:0] v);
        in_vld = 1'b1;
        in_sad = v;
        #1;
        chk({tag, ".in_rdy"}, 32'(in_rdy), 32'd1);
        @(posedge clk);
        #1;
        in_vld = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        clr     = 1'b0;
        in_vld  = 1'b0;
        in_sad  = '0;
        out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_vld",  32'(out_vld),      32'd0);
        chk("rst.blk_sad",  32'(out_blk_sad),  32'd0);
        chk("rst.best_sad", 32'(out_best_sad), 32'd0);
        chk("rst.win_done", 32'(out_win_done), 32'd0);
        chk("rst.in_rdy",   32'(in_rdy),       32'd1);
        rst_n = 1'b1;

        // Basic block
        send("b0", 10'd10);
        send("b0", 10'd20);
        send("b0", 10'd30);
        chk("b0.early_vld", 32'(out_vld), 32'd0);
        send("b0", 10'd40);
        chk_res("b0", 100, 0, 100, 0, 0);

        // Window with a tie, then wrap into a new window
        for (int i = 0; i < 4; i++) send("b1", 10'd15);
        chk_res("b1", 60, 1, 60, 1, 0);
        for (int i = 0; i < 4; i++) send("b2", 10'd15);
        chk_res("b2", 60, 2, 60, 1, 1);
        for (int i = 0; i < 4; i++) send("b3", 10'd50);
        chk_res("b3", 200, 0, 200, 0, 0);
        @(posedge clk);
        #1;
        chk("b3.drained", 32'(out_vld), 32'd0);

        // Backpressure: stall for 5 cycles with a beat of 7 held upstream
        pulse_clr();
        for (int i = 0; i < 3; i++) send("bp0", 10'd10);
        out_rdy = 1'b0;
        send("bp0", 10'd10);
        chk_res("bp0", 40, 0, 40, 0, 0);
        in_vld = 1'b1;
        in_sad = 10'd7;
        for (int i = 0; i < 5; i++) begin
            chk("bp.in_rdy",  32'(in_rdy),      32'd0);
            chk("bp.vld",     32'(out_vld),     32'd1);
            chk("bp.blk_sad", 32'(out_blk_sad), 32'd40);
            @(posedge clk);
            #1;
        end
        out_rdy = 1'b1;
        #1;
        chk("bp.release_rdy", 32'(in_rdy), 32'd1);
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        chk("bp.drained", 32'(out_vld), 32'd0);
        for (int i = 0; i < 2; i++) send("bp1", 10'd7);
        chk("bp1.early_vld", 32'(out_vld), 32'd0);
        send("bp1", 10'd7);
        chk_res("bp1", 28, 1, 28, 1, 0);

        // Maximum per-sample value
        pulse_clr();
        for (int i = 0; i < 4; i++) send("max", 10'd510);
        chk_res("max", 2040, 0, 2040, 0, 0);

        // Clear mid-block: partial sum and the beat presented during clr are dropped
        pulse_clr();
        send("cm", 10'd50);
        send("cm", 10'd50);
        clr    = 1'b1;
        in_vld = 1'b1;
        in_sad = 10'd50;
        #1;
        chk("cm.clr_rdy", 32'(in_rdy), 32'd0);
        @(posedge clk);
        #1;
        clr    = 1'b0;
        in_vld = 1'b0;
        chk("cm.clr_vld", 32'(out_vld), 32'd0);
        for (int i = 0; i < 3; i++) send("cm", 10'd1);
        chk("cm.early_vld", 32'(out_vld), 32'd0);
        send("cm", 10'd1);
        chk_res("cm", 4, 0, 4, 0, 0);

        // Async reset while block 1 is current and block 0's result is held
        pulse_clr();
        for (int i = 0; i < 3; i++) send("ar0", 10'd5);
        out_rdy = 1'b0;
        send("ar0", 10'd5);
        chk_res("ar0", 20, 0, 20, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar.async_vld",  32'(out_vld),     32'd0);
        chk("ar.async_sad",  32'(out_blk_sad), 32'd0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) send("ar1", 10'd1);
        chk_res("ar1", 4, 0, 4, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sad_accum.md
# sad_accum

Block-level SAD accumulator and best-match tracker. It sits directly downstream of the three-stage `sad` pipeline and consumes its `W+2`-bit per-pixel SAD stream through a valid/ready handshake. It sums `N` consecutive results into one block SAD and tracks the minimum block SAD over a search window of `M` blocks. Results are presented through a registered valid/ready output.

## Interface
- `W`, default 8: pixel width of the upstream pipe. The input SAD is `W+2` bits.
- `N`, default 16: SAD samples per block, `N >= 2`.
- `M`, default 8: blocks per search window, `M >= 2`.
- `ACCW`, default `W+2+$clog2(N)`: accumulator and block-SAD width.
- `IDXW`, default `$clog2(M)`: block index width.

Ports:
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `clr`, input, 1: synchronous clear; aborts the current block and window.
- `in_vld`, input, 1: upstream valid; connects to the pipe's `sad_vld`.
- `in_rdy`, output, 1: upstream ready; drives the pipe's `rdy_dn`.
- `in_sad`, input, `W+2`: per-sample SAD, unsigned.
- `out_vld`, output, 1: block result valid.
- `out_rdy`, input, 1: downstream ready.
- `out_blk_sad`, output, `ACCW`: SAD of the completed block.
- `out_blk_idx`, output, `IDXW`: index of the block within the window, 0..M-1.
- `out_best_sad`, output, `ACCW`: minimum block SAD in the window, up to and including this block.
- `out_best_idx`, output, `IDXW`: index of that minimum.
- `out_win_done`, output, 1: this block is the last block of the window (`idx == M-1`).

## Operation
- **Accept:** an input beat is accepted when `in_vld & in_rdy` at a rising edge.
- **Ready:** `in_rdy = ~clr & (~out_vld | out_rdy)`. This is combinational. No input is accepted while an undrained result is held.
- **State:** accumulator `acc` (`ACCW` bits), sample counter `cnt` (0..N-1), block counter `bidx` (0..M-1), and best registers `best_sad` / `best_idx`.
- **Accepted beat with `cnt < N-1`:**
  - `acc <= acc + in_sad`
  - `cnt <= cnt + 1`
- **Accepted beat with `cnt == N-1` (block complete):**
  - `blk = acc + in_sad`.
  - Output register loads `out_blk_sad = blk`, `out_blk_idx = bidx`, `out_win_done = (bidx == M-1)`.
  - Best update: if `bidx == 0` or `blk < best_sad` (strict), the best becomes `blk` / `bidx`. On a tie the earlier block is kept.
  - `out_best_sad` / `out_best_idx` load the updated best.
  - `out_vld <= 1`, `acc <= 0`, `cnt <= 0`.
  - `bidx` increments, wrapping `M-1 -> 0`. The wrap starts a new window; the best is overwritten by the next `bidx == 0` block.
- **Drain:** `out_vld & out_rdy` with no new completion clears `out_vld <= 0`. If a completion occurs in the same cycle as a drain, the output reloads and `out_vld` stays 1.
- **Output stability:** while `out_vld & ~out_rdy`, all `out_*` fields hold their values.
- **Arithmetic:** all unsigned. `ACCW` is sized so that `N*(2^(W+1)-2)` cannot overflow; no saturation logic is present.
- **`clr`:** takes priority over everything else. Next state is `acc=0`, `cnt=0`, `bidx=0`, `best_sad=0`, `best_idx=0`, `out_vld=0`. Any pending result is discarded, and the input beat in that cycle is not accepted (`in_rdy=0`).

## Timing
- **Reset values:** all registers are 0, so `out_vld=0`, all `out_*` data fields are 0, and `out_win_done=0`.
  - `in_rdy` is 1 after reset, with `clr` low.
  - Reset asserted mid-block or mid-window drops `out_vld` immediately, asynchronously, and loses the partial sums.
- **Latency:** `out_vld` rises on the same edge that accepts the Nth sample of a block, and is visible in the cycle after it.
- **Throughput:** one input beat per cycle with `out_rdy` held high, i.e. one block per `N` cycles, with no bubbles at block boundaries.
- **Backpressure:** with `out_rdy=0`, `in_rdy` falls in the cycle after `out_vld` rises. It stays 0 until the cycle in which `out_rdy=1`; that cycle both drains and may accept.
- **Path:** `in_rdy` depends combinationally on `out_rdy`, so the upstream pipe's stage-3 ready chain extends through this block. No combinational path exists from `in_vld` to `out_vld`.

## Test plan
All scenarios use `W=8`, `N=4`, `M=3`, `ACCW=12`, `IDXW=2`.
- **Basic block:** beats 10, 20, 30, 40 on consecutive cycles with `out_rdy=1` -> `out_vld` one cycle after the 4th accept, `out_blk_sad=100`, `idx=0`, `best=100/0`, `win_done=0`.
- **Window and tie:** block sums 100, 60, 60 -> the third result shows `best=60/1` (tie keeps earlier) and `win_done=1`. A next block sum of 200 -> `idx=0`, `best=200/0`, `win_done=0`.
- **Backpressure:** `out_rdy=0` after block 0 completes -> `in_rdy=0` and outputs frozen for 5 cycles while upstream holds `in_vld` with 7. Release `out_rdy` -> the held beat is accepted that cycle and no beat is lost or duplicated. The next block of 4×7 gives 28.
- **Maximum value:** four beats of 510 -> `out_blk_sad=2040`, with no wrap.
- **Clear mid-block:** beats 50, 50, then `clr` with `in_vld=1`, then four beats of 1 -> the first result is `out_blk_sad=4`, `idx=0`, `best=4/0`, and the beat during `clr` is ignored.
- **Async reset mid-window:** during block 1, assert `rst_n=0` -> `out_vld=0` in the same cycle. After release, the first result has `idx=0`.
